// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts a WIDTH-bit word on a valid/ready handshake and shifts it out MSB-first on x.
// Optional even-parity bit after the LSB when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             hold,
  output logic             x,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-2:0] shreg;     // bits still to send after the one on x
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             advance;
  logic             last_bit;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  assign accept   = din_valid && din_ready;
  assign advance  = (state != IDLE) && !hold;
  assign last_bit = (cnt == LAST);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (din_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
`ifdef BIT_SERIALIZER_PARITY_EN
        if (!hold && last_bit) state_nxt = PAR;
`else
        if (!hold && last_bit) state_nxt = IDLE;
`endif
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PAR: begin
        if (!hold) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decode the registered state only, never din_valid.
  always_comb begin
    din_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // Datapath: shift register, bit counter, serial line and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
      x     <= IDLE_BIT;
      done  <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        shreg <= din[WIDTH-2:0];
        cnt   <= '0;
        x     <= din[WIDTH-1];
`ifdef BIT_SERIALIZER_PARITY_EN
        par_q <= ^din;
`endif
      end else if (advance) begin
        case (state)
          SHIFT: begin
            if (!last_bit) begin
              cnt   <= cnt + 1'b1;
              x     <= shreg[WIDTH-2];
              shreg <= shreg << 1;
            end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
              x    <= par_q;
`else
              x    <= IDLE_BIT;
              done <= 1'b1;
`endif
            end
          end
`ifdef BIT_SERIALIZER_PARITY_EN
          PAR: begin
            x    <= IDLE_BIT;
            done <= 1'b1;
          end
`endif
          default: begin
            x <= IDLE_BIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed scenarios plus random frames against a queue-based frame model.
module tb_bit_serializer;

  localparam int   W    = 8;
  localparam logic IDLE = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int   FRAME = W + 1;
`else
  localparam int   FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         hold;
  logic         x;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  bit_serializer #(.WIDTH(W), .IDLE_BIT(IDLE)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .hold(hold), .x(x), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a queue of bits; each unheld edge emits the next one, an empty queue ends the frame.
  bit   m_q[$];
  bit   m_active;
  bit   m_done;
  bit   m_acc;
  logic m_x;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_acc    = 1'b0;
    m_x      = IDLE;
  endtask

  task automatic model_edge();
    m_acc  = 1'b0;
    m_done = 1'b0;
    if (!rst) begin
      model_reset();
    end else if (!m_active) begin
      m_x = IDLE;
      if (din_valid) begin
        for (int i = W - 1; i >= 0; i--) m_q.push_back(din[i]);
`ifdef BIT_SERIALIZER_PARITY_EN
        m_q.push_back(^din);
`endif
        m_x      = m_q.pop_front();
        m_active = 1'b1;
        m_acc    = 1'b1;
      end
    end else if (!hold) begin
      if (m_q.size() > 0) begin
        m_x = m_q.pop_front();
      end else begin
        m_x      = IDLE;
        m_done   = 1'b1;
        m_active = 1'b0;
      end
    end
  endtask

  // One clock: update the model at the edge, compare all outputs 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("x", x, m_x);
    check("busy", busy, m_active);
    check("done", done, m_done);
    check("din_ready", din_ready, !m_active);
  endtask

  // Send one word; hold is asserted for hold_len edges starting hold_at edges after accept, or randomly.
  task automatic send_word(input logic [W-1:0] w, input int hold_at, input int hold_len,
                           input bit rand_hold, input string tag);
    int  k;
    int  nholds;
    bit  got_acc;
    bit  got_done;
    din       = w;
    din_valid = 1'b1;
    got_acc   = 1'b0;
    for (int i = 0; i < 40 && !got_acc; i++) begin
      hold = rand_hold ? ($urandom_range(0, 1) == 1) : 1'b0;
      cycle();
      got_acc = m_acc;
    end
    din_valid = 1'b0;
    if (!got_acc) begin
      check({tag, "_accept_timeout"}, 0, 1);
      return;
    end
    din      = W'($urandom);
    k        = 0;
    nholds   = 0;
    got_done = 1'b0;
    while (k < 60 && !got_done) begin
      if (rand_hold) hold = ($urandom_range(0, 3) == 0);
      else           hold = (k >= hold_at && k < hold_at + hold_len);
      if (hold) nholds++;
      cycle();
      k++;
      got_done = done;
    end
    hold = 1'b0;
    check({tag, "_latency"}, k, FRAME + nholds);
  endtask

  initial begin
    int dn;
    int acc_n;
    int acc_t[2];

    rst       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    hold      = 1'b0;
    model_reset();
    repeat (3) cycle();
    rst = 1'b1;
    repeat (2) cycle();

    // Reset asserted mid-simulation while inputs try to start a frame, then 10 quiet cycles.
    din       = 8'h3C;
    din_valid = 1'b1;
    hold      = 1'b1;
    rst       = 1'b0;
    model_reset();
    #1;
    check("rst_x", x, IDLE);
    check("rst_busy", busy, 0);
    check("rst_ready", din_ready, 1);
    repeat (3) cycle();
    din_valid = 1'b0;
    hold      = 1'b0;
    rst       = 1'b1;
    repeat (10) cycle();

    // Basic frames, including the parity patterns (A5 -> parity 0, 07 -> parity 1).
    send_word(8'hA5, 0, 0, 1'b0, "a5");
    cycle();
    send_word(8'h07, 0, 0, 1'b0, "h07");
    cycle();

    // Hold for 3 edges after bit 2 is on the line.
    send_word(8'hF0, 2, 3, 1'b0, "hold");
    check("hold_total", 8'hF0 == 8'hF0 ? FRAME + 3 : 0, FRAME + 3);
    cycle();

    // Reset after bit 4 of FF: frame aborts with no done pulse.
    din       = 8'hFF;
    din_valid = 1'b1;
    cycle();
    check("abort_accept", m_acc, 1);
    din_valid = 1'b0;
    repeat (4) cycle();
    check("abort_pre_x", x, 1);
    rst = 1'b0;
    model_reset();
    #1;
    check("abort_x", x, IDLE);
    check("abort_busy", busy, 0);
    cycle();
    rst = 1'b1;
    dn  = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    send_word(8'h5A, 0, 0, 1'b0, "after_abort");
    cycle();

    // Back-to-back with din_valid held high.
    din       = 8'h01;
    din_valid = 1'b1;
    acc_n     = 0;
    dn        = 0;
    acc_t     = '{0, 0};
    for (int k = 0; k < 60 && dn < 2; k++) begin
      cycle();
      if (done) dn++;
      if (m_acc && acc_n < 2) begin
        acc_t[acc_n] = cyc;
        acc_n++;
        if (acc_n == 1) din = 8'h80;
        else            din_valid = 1'b0;
      end
    end
    din_valid = 1'b0;
    check("b2b_accepts", acc_n, 2);
    check("b2b_gap", acc_t[1] - acc_t[0], FRAME + 1);
    check("b2b_dones", dn, 2);
    cycle();

    // Random words with random hold and random idle gaps.
    for (int f = 0; f < 40; f++) begin
      send_word(W'($urandom), 0, 0, 1'b1, "rand");
      repeat ($urandom_range(0, 3)) begin
        hold = $urandom_range(0, 1) == 1;
        cycle();
      end
      hold = 1'b0;
    end
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
